// File: rtl/instr_fetch.sv
// instr_fetch
// Fetch stage between the warp scheduler and the instruction buffer. Scheduled
// warps issue word-aligned icache requests tagged with their warp id; per-warp
// metadata waits in a pending table until the response returns, then the joined
// packet leaves through a registered 2-entry skid buffer.
module instr_fetch #(
   parameter  int NUM_WARPS   = 4,
   parameter  int NUM_THREADS = 4,
   parameter  int XLEN        = 32,
   parameter  int UUID_W      = 44,
   parameter  int PERF_W      = 44,
   localparam int NW_W        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
   input  logic                   clk,
   input  logic                   reset,

   input  logic                   sched_valid,
   output logic                   sched_ready,
   input  logic [NW_W-1:0]        sched_wid,
   input  logic [NUM_THREADS-1:0] sched_tmask,
   input  logic [XLEN-1:0]        sched_pc,
   input  logic [UUID_W-1:0]      sched_uuid,

   output logic                   icache_req_valid,
   input  logic                   icache_req_ready,
   output logic [XLEN-3:0]        icache_req_addr,
   output logic [NW_W-1:0]        icache_req_tag,

   input  logic                   icache_rsp_valid,
   output logic                   icache_rsp_ready,
   input  logic [31:0]            icache_rsp_data,
   input  logic [NW_W-1:0]        icache_rsp_tag,

   input  logic [NUM_WARPS-1:0]   ibuf_full,

   output logic                   fetch_valid,
   input  logic                   fetch_ready,
   output logic [NW_W-1:0]        fetch_wid,
   output logic [NUM_THREADS-1:0] fetch_tmask,
   output logic [XLEN-1:0]        fetch_pc,
   output logic [UUID_W-1:0]      fetch_uuid,
   output logic [31:0]            fetch_instr,

   output logic                   busy,
   output logic [PERF_W-1:0]      perf_icache_stalls
);

   typedef struct packed {
      logic [NUM_THREADS-1:0] tmask;
      logic [XLEN-1:0]        pc;
      logic [UUID_W-1:0]      uuid;
   } meta_t;

   typedef struct packed {
      logic [NW_W-1:0] wid;
      meta_t           meta;
      logic [31:0]     instr;
   } pkt_t;

   logic [NUM_WARPS-1:0] pending_q, pending_d;
   logic                 wr_ptr_q, wr_ptr_d;
   logic                 rd_ptr_q, rd_ptr_d;
   logic [1:0]           count_q, count_d;
   logic [PERF_W-1:0]    stalls_q, stalls_d;

   meta_t tbl_q  [NUM_WARPS];
   pkt_t  skid_q [2];

   logic  blocked;
   logic  req_fire;
   logic  rsp_fire;
   logic  pop;
   logic  stall;
   pkt_t  rsp_pkt;
   pkt_t  head;

   // Request path: a warp is blocked while it has a fetch in flight or its
   // instruction buffer is almost full. No same-cycle bypass from a response.
   assign blocked          = pending_q[sched_wid] || ibuf_full[sched_wid];
   assign icache_req_valid = !reset && sched_valid && !blocked;
   assign sched_ready      = !reset && icache_req_ready && !blocked;
   assign icache_req_addr  = sched_pc[XLEN-1:2];
   assign icache_req_tag   = sched_wid;
   assign req_fire         = icache_req_valid && icache_req_ready;
   assign stall            = icache_req_valid && !icache_req_ready;

   // Response path: ready comes from the registered count only, so a full
   // buffer never accepts even if a pop happens in the same cycle.
   assign icache_rsp_ready = !reset && (count_q != 2'd2);
   assign rsp_fire         = icache_rsp_valid && icache_rsp_ready;
   assign rsp_pkt          = '{wid: icache_rsp_tag, meta: tbl_q[icache_rsp_tag], instr: icache_rsp_data};

   assign head        = skid_q[rd_ptr_q];
   assign fetch_valid = (count_q != 2'd0);
   assign fetch_wid   = head.wid;
   assign fetch_tmask = head.meta.tmask;
   assign fetch_pc    = head.meta.pc;
   assign fetch_uuid  = head.meta.uuid;
   assign fetch_instr = head.instr;
   assign pop         = fetch_valid && fetch_ready;

   assign busy               = (pending_q != '0) || fetch_valid;
   assign perf_icache_stalls = stalls_q;

   // Next-state for pending bits, skid pointers/count and the stall counter.
   always_comb begin
      // NOTE: every variable gets its default before any condition, so no path can infer a latch
      pending_d = pending_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      stalls_d  = stalls_q;

      // Clear before set: a stale response and a new request for the same
      // warp in one cycle leaves the new fetch marked pending.
      if (rsp_fire) pending_d[icache_rsp_tag] = 1'b0;
      if (req_fire) pending_d[sched_wid]      = 1'b1;

      if (rsp_fire) wr_ptr_d = ~wr_ptr_q;
      if (pop)      rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + 2'(rsp_fire) - 2'(pop);

      if (stall) stalls_d = stalls_q + PERF_W'(1);
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: sequential state uses <= so every flop samples pre-edge values
         pending_q <= '0;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         count_q   <= 2'd0;
         stalls_q  <= '0;
      end else begin
         pending_q <= pending_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         stalls_q  <= stalls_d;
      end
   end

   // Metadata table and skid storage writes.
   // NOTE: storage arrays carry no reset; their validity is tracked by pending_q and count_q
   always_ff @(posedge clk) begin
      if (req_fire) tbl_q[sched_wid] <= '{tmask: sched_tmask, pc: sched_pc, uuid: sched_uuid};
      if (rsp_fire) skid_q[wr_ptr_q] <= rsp_pkt;
   end

   // Protocol checks: responses must match an outstanding fetch, PCs must be word aligned.
   a_rsp_pending: assert property (@(posedge clk) disable iff (reset)
      rsp_fire |-> pending_q[icache_rsp_tag]);

   a_pc_align: assert property (@(posedge clk) disable iff (reset)
      icache_req_valid |-> (sched_pc[1:0] == 2'b00));

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations plus a
// queue-based model checked against the DUT on every falling edge.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        sched_valid;
   logic        sched_ready;
   logic [1:0]  sched_wid;
   logic [3:0]  sched_tmask;
   logic [31:0] sched_pc;
   logic [43:0] sched_uuid;
   logic        icache_req_valid;
   logic        icache_req_ready;
   logic [29:0] icache_req_addr;
   logic [1:0]  icache_req_tag;
   logic        icache_rsp_valid;
   logic        icache_rsp_ready;
   logic [31:0] icache_rsp_data;
   logic [1:0]  icache_rsp_tag;
   logic [3:0]  ibuf_full;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [1:0]  fetch_wid;
   logic [3:0]  fetch_tmask;
   logic [31:0] fetch_pc;
   logic [43:0] fetch_uuid;
   logic [31:0] fetch_instr;
   logic        busy;
   logic [43:0] perf_icache_stalls;

   int total = 0;
   int bad   = 0;

   instr_fetch dut (
      .clk(clk), .reset(reset),
      .sched_valid(sched_valid), .sched_ready(sched_ready), .sched_wid(sched_wid),
      .sched_tmask(sched_tmask), .sched_pc(sched_pc), .sched_uuid(sched_uuid),
      .icache_req_valid(icache_req_valid), .icache_req_ready(icache_req_ready),
      .icache_req_addr(icache_req_addr), .icache_req_tag(icache_req_tag),
      .icache_rsp_valid(icache_rsp_valid), .icache_rsp_ready(icache_rsp_ready),
      .icache_rsp_data(icache_rsp_data), .icache_rsp_tag(icache_rsp_tag),
      .ibuf_full(ibuf_full),
      .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_wid(fetch_wid),
      .fetch_tmask(fetch_tmask), .fetch_pc(fetch_pc), .fetch_uuid(fetch_uuid),
      .fetch_instr(fetch_instr),
      .busy(busy), .perf_icache_stalls(perf_icache_stalls)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [1:0]  wid;
      logic [3:0]  tmask;
      logic [31:0] pc;
      logic [43:0] uuid;
      logic [31:0] instr;
   } pkt_t;

   pkt_t        m_q [$];
   pkt_t        m_tbl [4];
   bit          m_pend [4];
   logic [43:0] m_stalls;
   bit          m_live = 0;

   function automatic bit m_busy();
      return m_pend[0] || m_pend[1] || m_pend[2] || m_pend[3] || (m_q.size() != 0);
   endfunction

   function automatic bit m_blocked(input logic [1:0] w);
      return m_pend[w] || ibuf_full[w];
   endfunction

   always @(posedge clk) begin
      bit   pf, sf, rf, st;
      pkt_t p;
      if (reset) begin
         m_q.delete();
         for (int i = 0; i < 4; i++) m_pend[i] = 0;
         m_stalls = '0;
         m_live   = 1;
      end else if (m_live) begin
         pf = (m_q.size() != 0) && fetch_ready;
         sf = icache_rsp_valid && (m_q.size() < 2);
         rf = sched_valid && icache_req_ready && !m_blocked(sched_wid);
         st = sched_valid && !icache_req_ready && !m_blocked(sched_wid);
         if (pf) void'(m_q.pop_front());
         if (sf) begin
            p       = m_tbl[icache_rsp_tag];
            p.wid   = icache_rsp_tag;
            p.instr = icache_rsp_data;
            m_q.push_back(p);
            m_pend[icache_rsp_tag] = 0;
         end
         if (rf) begin
            m_tbl[sched_wid].tmask = sched_tmask;
            m_tbl[sched_wid].pc    = sched_pc;
            m_tbl[sched_wid].uuid  = sched_uuid;
            m_pend[sched_wid]      = 1;
         end
         if (st) m_stalls = m_stalls + 44'd1;
      end
   end

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_live) begin
         check("fetch_valid", 64'(fetch_valid), 64'(m_q.size() != 0));
         if (m_q.size() != 0) begin
            check("fetch_wid",   64'(fetch_wid),   64'(m_q[0].wid));
            check("fetch_tmask", 64'(fetch_tmask), 64'(m_q[0].tmask));
            check("fetch_pc",    64'(fetch_pc),    64'(m_q[0].pc));
            check("fetch_uuid",  64'(fetch_uuid),  64'(m_q[0].uuid));
            check("fetch_instr", 64'(fetch_instr), 64'(m_q[0].instr));
         end
         check("busy",        64'(busy),               64'(m_busy()));
         check("perf",        64'(perf_icache_stalls), 64'(m_stalls));
         check("rsp_ready",   64'(icache_rsp_ready),   64'(!reset && (m_q.size() < 2)));
         check("sched_ready", 64'(sched_ready),
               64'(!reset && icache_req_ready && !m_blocked(sched_wid)));
         if (!reset) begin
            check("req_valid", 64'(icache_req_valid), 64'(sched_valid && !m_blocked(sched_wid)));
            if (icache_req_valid) begin
               check("req_addr", 64'(icache_req_addr), 64'(sched_pc[31:2]));
               check("req_tag",  64'(icache_req_tag),  64'(sched_wid));
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input logic [1:0] w, input logic [31:0] pc,
                         input logic [3:0] tm, input logic [43:0] id);
      sched_valid = 1'b1; sched_wid = w; sched_pc = pc; sched_tmask = tm; sched_uuid = id;
      #1;
      for (int i = 0; i < 32 && !sched_ready; i++) tick();
      check("req_accept_wait", 64'(sched_ready), 64'd1);
      tick();
      sched_valid = 1'b0;
   endtask

   task automatic do_rsp(input logic [1:0] tag, input logic [31:0] data);
      icache_rsp_valid = 1'b1; icache_rsp_tag = tag; icache_rsp_data = data;
      #1;
      for (int i = 0; i < 32 && !icache_rsp_ready; i++) tick();
      check("rsp_accept_wait", 64'(icache_rsp_ready), 64'd1);
      tick();
      icache_rsp_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      reset = 1'b1; sched_valid = 1'b0; sched_wid = '0; sched_tmask = '0; sched_pc = '0;
      sched_uuid = '0; icache_req_ready = 1'b1; icache_rsp_valid = 1'b0;
      icache_rsp_data = '0; icache_rsp_tag = '0; ibuf_full = '0; fetch_ready = 1'b1;
      tick(); tick();
      check("reset_busy",     64'(busy), 64'd0);
      check("reset_fvalid",   64'(fetch_valid), 64'd0);
      check("reset_perf",     64'(perf_icache_stalls), 64'd0);
      check("reset_sready",   64'(sched_ready), 64'd0);
      check("reset_rspready", 64'(icache_rsp_ready), 64'd0);
      reset = 1'b0;
      tick();

      // Single fetch
      sched_valid = 1'b1; sched_wid = 2'd1; sched_pc = 32'h8000_0000;
      sched_tmask = 4'b0001; sched_uuid = 44'd5;
      #1;
      check("t1_req_valid", 64'(icache_req_valid), 64'd1);
      check("t1_req_addr",  64'(icache_req_addr), 64'h2000_0000);
      check("t1_req_tag",   64'(icache_req_tag), 64'd1);
      check("t1_sready",    64'(sched_ready), 64'd1);
      tick();
      sched_valid = 1'b0;
      tick(); tick();
      check("t1_busy_wait", 64'(busy), 64'd1);
      do_rsp(2'd1, 32'h0000_0013);
      check("t1_fvalid", 64'(fetch_valid), 64'd1);
      check("t1_fwid",   64'(fetch_wid), 64'd1);
      check("t1_ftmask", 64'(fetch_tmask), 64'b0001);
      check("t1_fpc",    64'(fetch_pc), 64'h8000_0000);
      check("t1_fuuid",  64'(fetch_uuid), 64'd5);
      check("t1_finstr", 64'(fetch_instr), 64'h13);
      tick();
      check("t1_busy_done", 64'(busy), 64'd0);

      // Per-warp block, no same-cycle bypass
      do_req(2'd2, 32'h0000_0040, 4'b1111, 44'd20);
      sched_valid = 1'b1; sched_wid = 2'd2; sched_pc = 32'h0000_0044; sched_uuid = 44'd21;
      #1;
      check("t2_blocked", 64'(sched_ready), 64'd0);
      tick(); tick();
      icache_rsp_valid = 1'b1; icache_rsp_tag = 2'd2; icache_rsp_data = 32'hAAAA_0001;
      #1;
      check("t2_blocked_rsp_cycle", 64'(sched_ready), 64'd0);
      tick();
      icache_rsp_valid = 1'b0;
      #1;
      check("t2_ready_next",  64'(sched_ready), 64'd1);
      check("t2_pkt_pc",      64'(fetch_pc), 64'h40);
      tick();
      sched_valid = 1'b0;
      do_rsp(2'd2, 32'hAAAA_0002);
      check("t2_pkt2_pc",     64'(fetch_pc), 64'h44);
      tick();

      // Out-of-order responses
      for (int w = 0; w < 4; w++)
         do_req(2'(w), 32'((w + 1) * 32'h100), 4'(1 << w), 44'(100 + w));
      do_rsp(2'd3, 32'hB000_0003);
      check("t3_wid_a", 64'(fetch_wid), 64'd3);
      check("t3_pc_a",  64'(fetch_pc), 64'h400);
      do_rsp(2'd1, 32'hB000_0001);
      check("t3_wid_b", 64'(fetch_wid), 64'd1);
      check("t3_pc_b",  64'(fetch_pc), 64'h200);
      do_rsp(2'd0, 32'hB000_0000);
      check("t3_wid_c", 64'(fetch_wid), 64'd0);
      check("t3_pc_c",  64'(fetch_pc), 64'h100);
      do_rsp(2'd2, 32'hB000_0002);
      check("t3_wid_d", 64'(fetch_wid), 64'd2);
      check("t3_pc_d",  64'(fetch_pc), 64'h300);
      tick();

      // Backpressure on the skid buffer
      for (int w = 0; w < 3; w++)
         do_req(2'(w), 32'(32'h500 + w * 32'h100), 4'b0011, 44'(200 + w));
      fetch_ready = 1'b0;
      do_rsp(2'd0, 32'hC000_0000);
      do_rsp(2'd1, 32'hC000_0001);
      icache_rsp_valid = 1'b1; icache_rsp_tag = 2'd2; icache_rsp_data = 32'hC000_0002;
      #1;
      check("t4_full", 64'(icache_rsp_ready), 64'd0);
      tick(); tick(); tick();
      check("t4_hold_wid",   64'(fetch_wid), 64'd0);
      check("t4_hold_instr", 64'(fetch_instr), 64'hC000_0000);
      check("t4_still_full", 64'(icache_rsp_ready), 64'd0);
      fetch_ready = 1'b1;
      #1;
      check("t4_ready_regd", 64'(icache_rsp_ready), 64'd0);
      tick();
      check("t4_rel_wid1",   64'(fetch_wid), 64'd1);
      check("t4_rel_ready",  64'(icache_rsp_ready), 64'd1);
      tick();
      icache_rsp_valid = 1'b0;
      check("t4_rel_wid2",   64'(fetch_wid), 64'd2);
      check("t4_rel_pc2",    64'(fetch_pc), 64'h700);
      tick();
      check("t4_drained",    64'(fetch_valid), 64'd0);

      // ibuf_full gating and stall counting
      ibuf_full = 4'b0010;
      sched_valid = 1'b1; sched_wid = 2'd1; sched_pc = 32'h0000_0A00;
      #1;
      check("t5_ibuf_valid", 64'(icache_req_valid), 64'd0);
      check("t5_ibuf_ready", 64'(sched_ready), 64'd0);
      tick(); tick();
      sched_wid = 2'd0; sched_pc = 32'h0000_0800; sched_uuid = 44'd300;
      #1;
      check("t5_w0_valid", 64'(icache_req_valid), 64'd1);
      tick();
      sched_valid = 1'b0; ibuf_full = 4'b0000;
      check("t5_perf0", 64'(perf_icache_stalls), 64'd0);
      icache_req_ready = 1'b0;
      sched_valid = 1'b1; sched_wid = 2'd3; sched_pc = 32'h0000_0900; sched_uuid = 44'd301;
      for (int i = 0; i < 7; i++) tick();
      check("t5_perf7", 64'(perf_icache_stalls), 64'd7);
      icache_req_ready = 1'b1;
      tick();
      sched_valid = 1'b0;
      check("t5_perf7_hold", 64'(perf_icache_stalls), 64'd7);

      // Reset mid-operation: warps 3 and 1 outstanding, warp 0 packet buffered
      fetch_ready = 1'b0;
      do_rsp(2'd0, 32'hD000_0000);
      do_req(2'd1, 32'h0000_0A00, 4'b0101, 44'd302);
      check("t6_pre_busy",   64'(busy), 64'd1);
      check("t6_pre_fvalid", 64'(fetch_valid), 64'd1);
      reset = 1'b1;
      tick();
      check("t6_busy",     64'(busy), 64'd0);
      check("t6_fvalid",   64'(fetch_valid), 64'd0);
      check("t6_perf",     64'(perf_icache_stalls), 64'd0);
      check("t6_sready",   64'(sched_ready), 64'd0);
      check("t6_rspready", 64'(icache_rsp_ready), 64'd0);
      reset = 1'b0; fetch_ready = 1'b1;
      sched_valid = 1'b1; sched_wid = 2'd3; sched_pc = 32'h0000_0B00; sched_uuid = 44'd400;
      #1;
      check("t6_reaccept", 64'(sched_ready), 64'd1);
      tick();
      sched_valid = 1'b0;
      do_rsp(2'd3, 32'hE000_0003);
      check("t6_pkt_pc",   64'(fetch_pc), 64'hB00);
      check("t6_pkt_uuid", 64'(fetch_uuid), 64'd400);
      tick();
      check("t6_idle", 64'(busy), 64'd0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch stage between the warp scheduler and the instruction buffer. It takes scheduled warps (wid, tmask, PC, uuid), issues word-aligned requests to the instruction cache with the warp id as tag, and keeps the per-warp metadata in a pending table. On each cache response it joins the instruction word with the stored metadata and emits a fetch packet downstream through a registered 2-entry skid buffer.

## Interface
- NUM_WARPS, 4, warps per core; NW_W = max(1, clog2(NUM_WARPS))
- NUM_THREADS, 4, threads per warp
- XLEN, 32, PC width
- UUID_W, 44, instruction uuid width
- PERF_W, 44, perf counter width
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- sched_valid  in  1  scheduled warp valid
- sched_ready  out  1  stage accepts scheduled warp
- sched_wid  in  NW_W  warp id
- sched_tmask  in  NUM_THREADS  thread mask
- sched_pc  in  XLEN  warp PC, bits [1:0] always 0
- sched_uuid  in  UUID_W  instruction uuid
- icache_req_valid  out  1  cache request valid
- icache_req_ready  in  1  cache accepts request
- icache_req_addr  out  XLEN-2  word address = sched_pc[XLEN-1:2]
- icache_req_tag  out  NW_W  equals sched_wid
- icache_rsp_valid  in  1  cache response valid
- icache_rsp_ready  out  1  stage accepts response
- icache_rsp_data  in  32  instruction word
- icache_rsp_tag  in  NW_W  warp id of response
- ibuf_full  in  NUM_WARPS  per-warp instruction buffer almost-full
- fetch_valid  out  1  fetch packet valid
- fetch_ready  in  1  downstream accepts packet
- fetch_wid, fetch_tmask, fetch_pc, fetch_uuid, fetch_instr  out  NW_W/NUM_THREADS/XLEN/UUID_W/32  packet fields
- busy  out  1  any request outstanding or packet buffered
- perf_icache_stalls  out  PERF_W  cycles with icache_req_valid && !icache_req_ready

## Operation
- Pending table: per warp one entry {tmask, pc, uuid} plus a pending bit. At most one outstanding fetch per warp.
- Request path is combinational. icache_req_valid = sched_valid && !pending[sched_wid] && !ibuf_full[sched_wid]. sched_ready = icache_req_ready && !pending[sched_wid] && !ibuf_full[sched_wid].
- On request fire: write the table entry for sched_wid and set pending[sched_wid].
- Response path: icache_rsp_ready = skid buffer not full. On response fire: read the entry at icache_rsp_tag, push {tag, tmask, pc, uuid, data} into the skid buffer, and clear pending[tag].
- Skid buffer: 2 entries, FIFO order; fetch fields are driven from the head entry; pop on fetch_valid && fetch_ready.
- busy = (pending != 0) || fetch_valid.
- perf_icache_stalls increments by 1 per stall cycle and wraps modulo 2^PERF_W.
- Error checks (simulation assertions): a response whose tag has pending=0, and a request with sched_pc[1:0] != 0. The response with pending=0 is still forwarded using stale table contents.

## Timing
- Reset values: pending = 0, skid buffer empty, fetch_valid = 0, busy = 0, perf_icache_stalls = 0. Table contents are don't-care. During reset, sched_ready = 0 and icache_rsp_ready = 0.
- Request latency is 0 cycles: sched fire and icache request fire occur in the same cycle.
- Response-to-fetch latency is 1 cycle: a response fire in cycle N gives fetch_valid in cycle N+1.
- Full rate: with fetch_ready = 1, one packet per cycle is sustained.
- Skid buffer full (2 entries): icache_rsp_ready = 0. A push and a pop in the same cycle on a full buffer is not allowed; ready is taken from the registered count.
- Same wid, same cycle: a response for wid W and a new request for W in the same cycle. The request is blocked because pending[W] is still 1; it may fire in cycle N+1. There is no same-cycle bypass.
- Responses for different warps may return in any order. Each output packet carries its own warp's metadata.
- Reset mid-operation clears all pending bits and the buffer. Responses arriving after reset deasserts, for requests issued before reset, are the cache's responsibility (the cache is reset together with this block).
- Holding rules: sched_* and icache_req_* must be held while valid && !ready. fetch_* is held stable while fetch_valid && !fetch_ready.

## Test plan
- Single fetch: wid=1, pc=0x80000000, tmask=4'b0001, uuid=5; cache responds 3 cycles later with 0x00000013. Required: icache_req_addr = 0x20000000, tag = 1; fetch packet (1, 0001, 0x80000000, 5, 0x13) one cycle after the response; busy drops after pop.
- Per-warp block: wid=2 pending, sched offers wid=2 again → sched_ready = 0. Response returns in cycle N → request accepted no earlier than N+1.
- Out-of-order responses: warps 0,1,2,3 requested at PCs 0x100/0x200/0x300/0x400; responses return in order 3,1,0,2. Required: packets appear in order 3,1,0,2 with the matching PCs.
- Backpressure: fetch_ready = 0 for 5 cycles with 3 responses offered. Required: 2 responses accepted, then icache_rsp_ready = 0. After release, all 3 packets delivered in order with no loss.
- ibuf_full[1] = 1 → no request for wid 1 while wid 0 still proceeds. Then icache_req_ready = 0 for 7 cycles with a request pending → perf_icache_stalls = 7.
- Reset asserted with 2 outstanding requests and 1 buffered packet. Required: next cycle busy = 0, fetch_valid = 0, and a new request for the same wid is accepted.
